// File: rtl/shader_program_sequencer.sv
// Shader program sequencer: stores NUM_INSTR instruction bytes and streams them
// to the executor one per cycle, once per pixel start.
module shader_program_sequencer #(
  parameter int NUM_INSTR = 8,
  localparam int ADDR_W = $clog2(NUM_INSTR)
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_start_i,
  input  logic       load_valid_i,
  input  logic [7:0] load_data_i,
  output logic       load_ready_o,
  input  logic       pixel_start_i,
  output logic [7:0] instr_o,
  output logic       execute_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       overrun_o
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [7:0]        mem_q [NUM_INSTR];
  logic [7:0]        mem_d [NUM_INSTR];
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W-1:0] rptr_q, rptr_d;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        instr_q, instr_d;
  logic              execute_q, execute_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              overrun_q, overrun_d;
  logic              load_fire;

  // Load handshake: a byte transfers in any cycle where load_valid_i and
  // load_ready_o are both high; the host may hold valid while ready is low.
  assign load_ready_o = (state_q == IDLE) && !pixel_start_i && !rst_i;
  assign load_fire    = load_valid_i && load_ready_o;
  assign wr_addr      = load_start_i ? '0 : wptr_q;

  always_comb begin
    state_d   = state_q;
    mem_d     = mem_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    instr_d   = instr_q;
    execute_d = execute_q;
    busy_d    = busy_q;
    done_d    = done_q;
    overrun_d = overrun_q;
    case (state_q)
      IDLE: begin
        if (load_start_i) begin
          wptr_d    = '0;
          overrun_d = 1'b0;
        end
        if (load_fire) begin
          mem_d[wr_addr] = load_data_i;
          wptr_d         = wr_addr + 1'b1;
        end
        // rptr holds the index of the next slot to issue; slot 0 goes out now.
        if (pixel_start_i) begin
          state_d   = RUN;
          busy_d    = 1'b1;
          execute_d = 1'b1;
          done_d    = 1'b0;
          instr_d   = mem_q[0];
          rptr_d    = ADDR_W'(1);
        end
      end
      RUN: begin
        if (pixel_start_i) overrun_d = 1'b1;
        if (done_q) begin
          state_d   = IDLE;
          execute_d = 1'b0;
          busy_d    = 1'b0;
          done_d    = 1'b0;
          rptr_d    = '0;
        end else begin
          instr_d = mem_q[rptr_q];
          rptr_d  = rptr_q + 1'b1;
          done_d  = (rptr_q == ADDR_W'(NUM_INSTR - 1));
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      for (int i = 0; i < NUM_INSTR; i++) mem_q[i] <= 8'h00;
      wptr_q    <= '0;
      rptr_q    <= '0;
      instr_q   <= 8'h00;
      execute_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mem_q     <= mem_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      instr_q   <= instr_d;
      execute_q <= execute_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
    end
  end

  assign instr_o   = instr_q;
  assign execute_o = execute_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign overrun_o = overrun_q;

endmodule

// File: tb/tb_shader_program_sequencer.sv
// Directed bench for shader_program_sequencer: table-driven load/run vectors
// plus hand-written sequences for backpressure, overrun, wrap and reset.
module tb_shader_program_sequencer;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       load_start_i = 1'b0;
  logic       load_valid_i = 1'b0;
  logic [7:0] load_data_i = 8'h00;
  logic       load_ready_o;
  logic       pixel_start_i = 1'b0;
  logic [7:0] instr_o;
  logic       execute_o, busy_o, done_o, overrun_o;

  shader_program_sequencer #(.NUM_INSTR(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .load_start_i(load_start_i), .load_valid_i(load_valid_i),
    .load_data_i(load_data_i), .load_ready_o(load_ready_o),
    .pixel_start_i(pixel_start_i), .instr_o(instr_o),
    .execute_o(execute_o), .busy_o(busy_o), .done_o(done_o),
    .overrun_o(overrun_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic       ls;
    logic       lv;
    logic [7:0] d;
    logic       pix;
    logic       e_ready;
    logic [7:0] e_instr;
    logic       e_exec;
    logic       e_busy;
    logic       e_done;
  } vec_t;

  vec_t       tbl [18];
  logic [7:0] prog [8];
  logic [7:0] model_mem [8];
  logic [2:0] model_wptr;
  logic [7:0] exp_q [$];
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) model_mem[i] = 8'h00;
    model_wptr = 3'd0;
  endtask

  task automatic load_byte(input logic [7:0] d, input logic start);
    load_valid_i = 1'b1;
    load_data_i  = d;
    load_start_i = start;
    #1;
    chk("load_ready", load_ready_o, 1'b1);
    tick();
    if (start) model_wptr = 3'd0;
    model_mem[model_wptr] = d;
    model_wptr++;
    load_valid_i = 1'b0;
    load_start_i = 1'b0;
  endtask

  // Runs one pixel, checking every issued slot against the model program.
  task automatic run_pixel(input string tag, input logic [7:0] ovr_mask);
    logic [7:0] e;
    for (int k = 0; k < 8; k++) exp_q.push_back(model_mem[k]);
    pixel_start_i = 1'b1;
    #1;
    chk({tag, "_ready_at_start"}, load_ready_o, 1'b0);
    tick();
    pixel_start_i = 1'b0;
    for (int k = 0; k < 8; k++) begin
      e = exp_q.pop_front();
      chk({tag, "_instr"}, instr_o, e);
      chk({tag, "_exec"}, execute_o, 1'b1);
      chk({tag, "_busy"}, busy_o, 1'b1);
      chk({tag, "_done"}, done_o, (k == 7));
      chk({tag, "_ready_run"}, load_ready_o, 1'b0);
      if (ovr_mask[k]) pixel_start_i = 1'b1;
      tick();
      pixel_start_i = 1'b0;
    end
    chk({tag, "_exec_end"}, execute_o, 1'b0);
    chk({tag, "_busy_end"}, busy_o, 1'b0);
    chk({tag, "_done_end"}, done_o, 1'b0);
  endtask

  initial begin
    prog = '{8'hC5, 8'h04, 8'h11, 8'h25, 8'h30, 8'h00, 8'hC0, 8'h4D};
    for (int i = 0; i < 8; i++)
      tbl[i] = '{(i == 0), 1'b1, prog[i], 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[8] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'hC5, 1'b1, 1'b1, 1'b0};
    for (int j = 1; j < 8; j++)
      tbl[8+j] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, prog[j], 1'b1, 1'b1, (j == 7)};
    tbl[16] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h4D, 1'b0, 1'b0, 1'b0};
    tbl[17] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h4D, 1'b0, 1'b0, 1'b0};

    // Reset state while rst_i is held.
    model_reset();
    #2;
    chk("rst_instr", instr_o, 8'h00);
    chk("rst_exec", execute_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_overrun", overrun_o, 1'b0);
    chk("rst_ready", load_ready_o, 1'b0);
    tick();
    tick();
    rst_i = 1'b0;
    tick();
    run_pixel("zero_run", 8'h00);

    // Load and run from the vector table.
    for (int i = 0; i < 18; i++) begin
      load_start_i  = tbl[i].ls;
      load_valid_i  = tbl[i].lv;
      load_data_i   = tbl[i].d;
      pixel_start_i = tbl[i].pix;
      #1;
      chk("tbl_ready", load_ready_o, tbl[i].e_ready);
      tick();
      chk("tbl_instr", instr_o, tbl[i].e_instr);
      chk("tbl_exec", execute_o, tbl[i].e_exec);
      chk("tbl_busy", busy_o, tbl[i].e_busy);
      chk("tbl_done", done_o, tbl[i].e_done);
      if (tbl[i].ls) model_wptr = 3'd0;
      if (tbl[i].lv && tbl[i].e_ready) begin
        model_mem[model_wptr] = tbl[i].d;
        model_wptr++;
      end
    end
    load_start_i = 1'b0;
    load_valid_i = 1'b0;
    pixel_start_i = 1'b0;

    // Backpressure: byte FF offered with pixel_start and held through the run.
    load_valid_i = 1'b1;
    load_data_i  = 8'hFF;
    run_pixel("bp_run", 8'h00);
    #1;
    chk("bp_ready_idle", load_ready_o, 1'b1);
    tick();
    load_valid_i = 1'b0;
    model_mem[model_wptr] = 8'hFF;
    model_wptr++;
    run_pixel("bp_check", 8'h00);

    // Overrun: extra starts at T+3 and in the done cycle.
    chk("ovr_before", overrun_o, 1'b0);
    run_pixel("ovr_run", 8'b1000_0100);
    chk("ovr_set", overrun_o, 1'b1);
    tick();
    chk("ovr_no_restart", execute_o, 1'b0);
    load_start_i = 1'b1;
    tick();
    load_start_i = 1'b0;
    model_wptr = 3'd0;
    chk("ovr_cleared", overrun_o, 1'b0);

    // Async reset in the middle of a run.
    pixel_start_i = 1'b1;
    tick();
    pixel_start_i = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    chk("mid_exec_pre", execute_o, 1'b1);
    #2;
    rst_i = 1'b1;
    #1;
    chk("mid_rst_exec", execute_o, 1'b0);
    chk("mid_rst_busy", busy_o, 1'b0);
    chk("mid_rst_instr", instr_o, 8'h00);
    tick();
    rst_i = 1'b0;
    model_reset();
    run_pixel("post_rst_run", 8'h00);

    // Pointer wrap: ten bytes without load_start.
    for (int b = 1; b <= 10; b++) load_byte(8'(b), 1'b0);
    run_pixel("wrap_run", 8'h00);

    // load_start coinciding with a fire puts the byte in slot 0.
    load_byte(8'hAA, 1'b1);
    load_byte(8'hBB, 1'b0);
    run_pixel("ls_fire_run", 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
